// File: rtl/uart_rx_core.sv
// uart_rx_core
// Oversampling 8N1 UART receiver. An internal divide-by-CLK_DIV tick
// generator gives 16 ticks per bit. Each bit is sampled at mid-bit, and the
// sampling phase locks to the falling edge of the start bit.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idle high
//   data       last good byte, LSB first on the line
//   valid      one-cycle pulse when data is updated
//   frame_err  one-cycle pulse on a bad stop bit (or a bad parity bit)
//   busy       high whenever the receiver is not idle
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s low
// S_START  | start bit seen, re-checked at tick 8
// S_DATA   | shifting in 8 data bits at ticks 24 + 16n
// S_PARITY | checking the parity bit at tick 152 (parity build only)
// S_STOP   | checking the stop bit at tick 152 (168 with parity)
module uart_rx_core #(
    parameter int unsigned CLK_DIV = 325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] DIV_LAST       = 16'(CLK_DIV - 1);
    localparam logic [7:0]  START_TICK     = 8'd8;
    localparam logic [7:0]  LAST_DATA_TICK = 8'd136;
`ifdef UART_RX_PARITY_EN
    localparam logic [7:0]  PARITY_TICK    = 8'd152;
    localparam logic [7:0]  STOP_TICK      = 8'd168;
`else
    localparam logic [7:0]  STOP_TICK      = 8'd152;
`endif

    logic        rx_meta_q, rx_s_q;
    state_t      state_q, state_d;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [7:0]  tick_cnt_q, tick_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic        par_err_q, par_err_d;
`endif

    logic        tick;
    logic [7:0]  tick_num;
    logic        frame_ok;

    assign tick     = (div_cnt_q == DIV_LAST);
    // Number of the tick currently being acted on, counted from START entry.
    assign tick_num = tick_cnt_q + 8'd1;

`ifdef UART_RX_PARITY_EN
    assign frame_ok = rx_s_q && !par_err_q;
`else
    assign frame_ok = rx_s_q;
`endif

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = tick ? 16'd0 : div_cnt_q + 16'd1;
        tick_cnt_d = tick_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif

        if (state_q != S_IDLE && tick) begin
            tick_cnt_d = tick_num;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    // Restart both counters so sampling is phase-locked to the start edge.
                    state_d    = S_START;
                    div_cnt_d  = 16'd0;
                    tick_cnt_d = 8'd0;
                end
            end
            S_START: begin
                if (tick && tick_num == START_TICK) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                // Data sample ticks 24, 40, ... 136 all have a low nibble of 8.
                if (tick && tick_num[3:0] == 4'd8) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (tick_num == LAST_DATA_TICK) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick && tick_num == PARITY_TICK) begin
                    par_err_d = ^{shift_q, rx_s_q};
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving here at mid-stop-bit lets a zero-gap start bit be caught.
                if (tick && tick_num == STOP_TICK) begin
                    state_d = S_IDLE;
                    if (frame_ok) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            div_cnt_q  <= 16'd0;
            tick_cnt_q <= 8'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core at CLK_DIV=4 (64 clocks per bit). Frames are
// driven one clock-edge-aligned bit at a time. The expected result of each
// frame is one event at (send edge + fixed latency). Works with or without
// UART_RX_PARITY_EN.
module tb_uart_rx_core;

    localparam int CLK_DIV  = 4;
    localparam int BIT_CLKS = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
    localparam int NBITS     = 11;
    localparam int STOP_T    = 168;
`else
    localparam bit PARITY_ON = 1'b0;
    localparam int NBITS     = 10;
    localparam int STOP_T    = 152;
`endif
    localparam int LAT        = 3 + STOP_T * CLK_DIV;
    localparam int FRAME_CLKS = NBITS * BIT_CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx_core #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int         edge_at;
        logic       v;
        logic       f;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        int   edge_at;
        logic b;
    } bz_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       par_bad;
        int         gap;
        logic       ev_v;
        logic       ev_f;
        logic [7:0] ev_d;
    } vec_t;

    ev_t  obs_q[$];
    ev_t  exp_q[$];
    bz_t  busy_q[$];
    logic busy_prev = 1'b0;
    bit   mon_en    = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid === 1'b1 || frame_err === 1'b1) begin
                obs_q.push_back('{edge_n, valid, frame_err, data});
                chk("valid_ferr_exclusive", {31'd0, valid & frame_err}, 32'd0);
            end
            if (busy !== busy_prev) begin
                busy_q.push_back('{edge_n, busy});
                busy_prev = busy;
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_bad,
                              input int gap, output int e);
        e  = edge_n;
        rx = 1'b0;
        wait_edges(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_edges(BIT_CLKS);
        end
        if (PARITY_ON) begin
            rx = (^b) ^ par_bad;
            wait_edges(BIT_CLKS);
        end
        rx = stop;
        wait_edges(BIT_CLKS);
        rx = 1'b1;
        if (gap > 0) wait_edges(gap);
    endtask

    // Reference model: a frame sent at edge e produces exactly one event LAT
    // edges later; good frames update the held byte, bad ones repeat it.
    task automatic expect_frame(input logic [7:0] b, input logic stop, input logic par_bad,
                                input int e);
        if (!stop || (PARITY_ON && par_bad)) begin
            exp_q.push_back('{e + LAT, 1'b0, 1'b1, last_good});
        end else begin
            last_good = b;
            exp_q.push_back('{e + LAT, 1'b1, 1'b0, b});
        end
    endtask

    task automatic check_events(input string name);
        chk({name, "_count"}, obs_q.size(), exp_q.size());
        if (obs_q.size() == exp_q.size()) begin
            foreach (obs_q[i]) begin
                chk({name, "_edge"},  obs_q[i].edge_at, exp_q[i].edge_at);
                chk({name, "_valid"}, {31'd0, obs_q[i].v}, {31'd0, exp_q[i].v});
                chk({name, "_ferr"},  {31'd0, obs_q[i].f}, {31'd0, exp_q[i].f});
                chk({name, "_data"},  {24'd0, obs_q[i].d}, {24'd0, exp_q[i].d});
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_busy(input string name, input int rise_at, input int fall_at);
        chk({name, "_busy_count"}, busy_q.size(), 2);
        if (busy_q.size() == 2) begin
            chk({name, "_busy_rise"}, busy_q[0].edge_at, rise_at);
            chk({name, "_busy_rise_v"}, {31'd0, busy_q[0].b}, 32'd1);
            chk({name, "_busy_fall"}, busy_q[1].edge_at, fall_at);
            chk({name, "_busy_fall_v"}, {31'd0, busy_q[1].b}, 32'd0);
        end
        busy_q.delete();
    endtask

    vec_t tbl[6];
    int   e, e2;

    initial begin
        tbl[0] = '{8'h3C, 1'b0, 1'b0, 100, 1'b0, 1'b1, 8'hA5};
        tbl[1] = '{8'h00, 1'b1, 1'b0, 0,   1'b1, 1'b0, 8'h00};
        tbl[2] = '{8'hFF, 1'b1, 1'b0, 0,   1'b1, 1'b0, 8'hFF};
        tbl[3] = '{8'h55, 1'b1, 1'b0, 50,  1'b1, 1'b0, 8'h55};
        tbl[4] = '{8'h80, 1'b1, 1'b0, 10,  1'b1, 1'b0, 8'h80};
        tbl[5] = '{8'h01, 1'b0, 1'b0, 60,  1'b0, 1'b1, 8'h80};

        // Reset held for edges 1 and 2.
        rst = 1'b1;
        rx  = 1'b1;
        wait_edges(2);
        chk("reset_data",  {24'd0, data}, 32'h00);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_ferr",  {31'd0, frame_err}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single byte starting at edge 10.
        wait_edges(8);
        send_frame(8'hA5, 1'b1, 1'b0, 100, e);
        chk("single_start_edge", e, 10);
        expect_frame(8'hA5, 1'b1, 1'b0, e);
        check_events("single");
        check_busy("single", e + 3, e + LAT);

        // Start glitch: 20 clocks low, rejected at tick 8.
        e  = edge_n;
        rx = 1'b0;
        wait_edges(20);
        rx = 1'b1;
        wait_edges(100);
        check_events("glitch");
        check_busy("glitch", e + 3, e + 3 + 8 * CLK_DIV);

        // Directed table: framing errors, zero-gap back-to-back, MSB/LSB bytes.
        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].b, tbl[i].stop, tbl[i].par_bad, tbl[i].gap, e);
            exp_q.push_back('{e + LAT, tbl[i].ev_v, tbl[i].ev_f, tbl[i].ev_d});
            last_good = tbl[i].ev_d;
        end
        if (obs_q.size() >= 4) begin
            chk("b2b_spacing_1", obs_q[2].edge_at - obs_q[1].edge_at, FRAME_CLKS);
            chk("b2b_spacing_2", obs_q[3].edge_at - obs_q[2].edge_at, FRAME_CLKS);
        end
        check_events("table");
        busy_q.delete();

        // Break: line held low gives repeated frame errors, one START per frame.
        e  = edge_n;
        rx = 1'b0;
        wait_edges(2 * (LAT - 3) + 20);
        rx = 1'b1;
        wait_edges(200);
        exp_q.push_back('{e + LAT, 1'b0, 1'b1, last_good});
        exp_q.push_back('{e + 2 * LAT - 2, 1'b0, 1'b1, last_good});
        check_events("break");
        chk("break_data_kept", {24'd0, data}, {24'd0, last_good});

        // Reset during data bit 3 of 0x81, then a clean 0x7E.
        rx = 1'b0;
        wait_edges(BIT_CLKS);
        rx = 1'b1;
        wait_edges(BIT_CLKS);
        rx = 1'b0;
        wait_edges(2 * BIT_CLKS);
        rx = 1'b0;
        wait_edges(24);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        chk("pre_reset_data", {24'd0, data}, 32'h80);
        rst = 1'b1;
        rx  = 1'b1;
        wait_edges(1);
        chk("midreset_data",  {24'd0, data}, 32'h00);
        chk("midreset_valid", {31'd0, valid}, 32'd0);
        chk("midreset_ferr",  {31'd0, frame_err}, 32'd0);
        chk("midreset_busy",  {31'd0, busy}, 32'd0);
        rst       = 1'b0;
        last_good = 8'h00;
        wait_edges(100);
        check_events("abort");
        send_frame(8'h7E, 1'b1, 1'b0, 100, e2);
        expect_frame(8'h7E, 1'b1, 1'b0, e2);
        check_events("after_reset");
        busy_q.delete();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 20, e);
        expect_frame(8'h07, 1'b1, 1'b0, e);
        send_frame(8'h07, 1'b1, 1'b1, 20, e);
        expect_frame(8'h07, 1'b1, 1'b1, e);
        check_events("parity");
        chk("parity_data_kept", {24'd0, data}, 32'h07);
`endif

        // Randomized frames against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            logic       stop, par_bad;
            int         gap;
            b       = 8'($urandom_range(0, 255));
            stop    = ($urandom_range(0, 3) != 0);
            par_bad = PARITY_ON ? ($urandom_range(0, 3) == 0) : 1'b0;
            gap     = stop ? $urandom_range(0, 20) : $urandom_range(40, 80);
            send_frame(b, stop, par_bad, gap, e);
            expect_frame(b, stop, par_bad, e);
        end
        wait_edges(100);
        check_events("random");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
